ppi_strobed_port: RTL
=====================

Name: ppi_strobed_port

Overview:
- Mode-1 strobed handshake port for the PPI: an 8-bit port with the STB/IBF/ACK/OBF/INTR handshake.
- Sits between the CPU-side data bus and the peripheral-side port pins, alongside the simple unstrobed port.
- Direction follows the same `mode` convention as the simple port: mode=1 means peripheral to CPU (input), mode=0 means CPU to peripheral (output).
- Tri-state pads are instantiated at the top level; this block drives separate data and output-enable signals.

Parameters:
- WIDTH, 8, data width of port and bus.
- SYNC_STAGES, 2, flops in each synchronizer for `stb_n` and `ack_n` (minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  1 = strobed input, 0 = strobed output.
- enable  input  1  chip/port select; gates CPU access and both output enables.
- cpu_rd  input  1  one-cycle CPU read strobe.
- cpu_wr  input  1  one-cycle CPU write strobe.
- cpu_din  input  WIDTH  CPU write data.
- databus_out  output  WIDTH  read data to CPU bus.
- databus_oe  output  1  bus drive enable.
- port_in  input  WIDTH  peripheral data pins (input mode).
- port_out  output  WIDTH  peripheral data pins (output mode).
- port_oe  output  1  pin drive enable.
- stb_n  input  1  peripheral strobe, async.
- ibf  output  1  input buffer full.
- ack_n  input  1  peripheral acknowledge, async.
- obf_n  output  1  output buffer full, active low.
- inte  input  1  interrupt enable.
- intr  output  1  interrupt request to CPU.
- overrun  output  1  sticky: strobe arrived while ibf=1.

Behaviour:
- Reset (async, rst_n=0): all of the following are cleared immediately.
  - Outputs: ibf=0, obf_n=1, intr=0, overrun=0, databus_oe=0, port_oe=0, databus_out=0, port_out=0.
  - Internal: input latch=0, synchronizers to 1.
- Synchronization: `stb_n` and `ack_n` each pass through SYNC_STAGES flops plus one edge-detect flop. A pin edge is acted on SYNC_STAGES+1 clocks later.
- Output enables are combinational:
  - databus_oe = enable & mode & cpu_rd.
  - port_oe = enable & ~mode.
  - databus_out = input latch.
  - port_out = output latch.
- Input mode (mode=1), state machine EMPTY/FULL:
  - EMPTY, stb fall detected: latch port_in (raw), ibf=1, go FULL. The peripheral holds data stable for at least SYNC_STAGES+2 clocks after `stb_n` falls.
  - FULL, stb rise detected: intr=inte.
  - FULL, stb fall detected: latch unchanged, overrun=1, stay FULL.
  - cpu_rd & enable: data valid on databus_out in the same cycle. Next edge: ibf=0, intr=0, overrun=0, go EMPTY.
  - cpu_rd and stb fall in the same cycle: the read completes with the old data, then the new data is latched. Result is ibf=1, state FULL, no overrun.
- Output mode (mode=0), state machine EMPTY/FULL:
  - cpu_wr & enable: output latch=cpu_din, obf_n=0, intr=0, go FULL.
  - cpu_wr while FULL: data overwritten, obf_n stays 0.
  - FULL, ack fall detected: obf_n=1, go EMPTY.
  - EMPTY after ack, ack rise detected: intr=inte.
  - cpu_wr and ack fall in the same cycle: the write wins, obf_n=0, state FULL.
- inte deasserted: intr clears on the next clock. Handshake state is unaffected.
- enable=0:
  - cpu_rd and cpu_wr are ignored; both output enables are 0.
  - Peripheral handshake edges are still processed.
- mode change (any clock where mode differs from its registered value):
  - Cleared: ibf=0, obf_n=1, intr=0, overrun=0; both state machines go to EMPTY.
  - Data latches are retained.
- rst_n asserted mid-handshake: immediate return to reset values. The first edge after reset release is judged against the synchronizer's reset value of 1, so a pin already low produces one fall detection.

Test Plan:
- Input mode, inte=1, port_in=0x05:
  - Pulse stb_n low for 6 clocks, then high -> ibf=1 at 3 clocks after the fall; intr=1 at 3 clocks after the rise.
  - Then cpu_rd -> databus_out=0x05, databus_oe=1 for that cycle, then ibf=0 and intr=0.
- Input overrun:
  - Strobe in 0x05, then strobe in 0x06 without a read -> overrun=1, read returns 0x05.
  - After the read: overrun=0, ibf=0.
- Output mode, inte=1:
  - cpu_wr with 0x10 -> port_out=0x10, port_oe=1, obf_n=0.
  - ack_n pulse -> obf_n=1 3 clocks after the ack fall; intr=1 3 clocks after the ack rise.
  - Next cpu_wr clears intr.
- Boundary coincidences:
  - Output mode: cpu_wr of 0x22 in the same cycle as detected ack fall -> obf_n stays 0, port_out=0x22.
  - Input mode: cpu_rd in the same cycle as stb fall -> old byte read, new byte latched, ibf=1, overrun=0.
- Gating and mode switch:
  - enable=0 with cpu_wr/cpu_rd -> no latch change, databus_oe=port_oe=0.
  - Toggle mode while ibf=1 -> ibf=0, intr=0, obf_n=1.
  - Assert rst_n low mid-handshake -> all outputs go to reset values with no clock edge.

Source files
------------

// File: rtl/ppi_strobed_port.sv
// Mode-1 strobed handshake port: STB/IBF input side and OBF/ACK output side,
// with synchronized peripheral strobes and a sticky overrun flag.

module ppi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin_i,
   output logic fall_o,
   output logic rise_o
);
   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Reset to 1 so a pin already low after reset yields one fall detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pin_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign fall_o = prev_q & ~sync_q[STAGES-1];
   assign rise_o = ~prev_q & sync_q[STAGES-1];
endmodule

module ppi_strobed_port #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic             enable,
   input  logic             cpu_rd,
   input  logic             cpu_wr,
   input  logic [WIDTH-1:0] cpu_din,
   output logic [WIDTH-1:0] databus_out,
   output logic             databus_oe,
   input  logic [WIDTH-1:0] port_in,
   output logic [WIDTH-1:0] port_out,
   output logic             port_oe,
   input  logic             stb_n,
   output logic             ibf,
   input  logic             ack_n,
   output logic             obf_n,
   input  logic             inte,
   output logic             intr,
   output logic             overrun
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hs_state_e;

   hs_state_e        in_st_q, out_st_q;
   logic             mode_q, intr_q, ovr_q, obf_n_q;
   logic [WIDTH-1:0] in_lat_q, out_lat_q;
   logic             stb_fall, stb_rise, ack_fall, ack_rise;
   logic             rd_en, wr_en, mode_chg;

   ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_stb_sync (
      .clk(clk), .rst_n(rst_n), .pin_i(stb_n), .fall_o(stb_fall), .rise_o(stb_rise)
   );
   ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk(clk), .rst_n(rst_n), .pin_i(ack_n), .fall_o(ack_fall), .rise_o(ack_rise)
   );

   assign rd_en    = enable & mode & cpu_rd;
   assign wr_en    = enable & ~mode & cpu_wr;
   assign mode_chg = mode ^ mode_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_st_q   <= EMPTY;
         out_st_q  <= EMPTY;
         mode_q    <= 1'b0;
         intr_q    <= 1'b0;
         ovr_q     <= 1'b0;
         obf_n_q   <= 1'b1;
         in_lat_q  <= '0;
         out_lat_q <= '0;
      end else begin
         mode_q <= mode;
         if (mode_chg) begin
            in_st_q  <= EMPTY;
            out_st_q <= EMPTY;
            obf_n_q  <= 1'b1;
            intr_q   <= 1'b0;
            ovr_q    <= 1'b0;
         end else if (mode) begin
            // A read completes with the old byte; a coincident strobe refills it.
            if (rd_en) begin
               intr_q <= 1'b0;
               ovr_q  <= 1'b0;
               if (stb_fall) begin
                  in_lat_q <= port_in;
                  in_st_q  <= FULL;
               end else begin
                  in_st_q <= EMPTY;
               end
            end else if (in_st_q == EMPTY) begin
               if (stb_fall) begin
                  in_lat_q <= port_in;
                  in_st_q  <= FULL;
               end
            end else if (stb_fall) begin
               ovr_q <= 1'b1;
            end else if (stb_rise) begin
               intr_q <= inte;
            end
         end else begin
            if (wr_en) begin
               out_lat_q <= cpu_din;
               obf_n_q   <= 1'b0;
               intr_q    <= 1'b0;
               out_st_q  <= FULL;
            end else if (out_st_q == FULL) begin
               if (ack_fall) begin
                  obf_n_q  <= 1'b1;
                  out_st_q <= EMPTY;
               end
            end else if (ack_rise) begin
               intr_q <= inte;
            end
         end
         if (!inte) intr_q <= 1'b0;
      end
   end

   // Enables are gated by reset so the pads release while rst_n is low.
   assign databus_oe  = rst_n & rd_en;
   assign port_oe     = rst_n & enable & ~mode;
   assign databus_out = in_lat_q;
   assign port_out    = out_lat_q;
   assign ibf         = (in_st_q == FULL);
   assign obf_n       = obf_n_q;
   assign intr        = intr_q;
   assign overrun     = ovr_q;
endmodule
